// File: rtl/ibex_rf_wr_arbiter.sv
// ibex_rf_wr_arbiter
// Shares the register-file write port between the stallable ALU writeback
// and the non-stallable, in-order LSU load-response path. Destinations of
// outstanding loads are kept in a small circular FIFO. That FIFO drives the
// read-after-write hazards seen by ID and holds back younger ALU writes to a
// register that still has a load pending (write-after-write ordering).
// The write port and the hazards are combinational. rsp_err_o is registered:
// it pulses in the cycle after a response arrives with no load outstanding.
// Optional feature macro: IBEX_RF_WR_ARB_FWD_EN. When it is defined, a hazard
// is dropped in the cycle in which the load response writes that register.
module ibex_rf_wr_arbiter #(
  parameter bit          RV32E          = 1'b0,
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned LsuOutstanding = 2
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic                                  alu_valid_i,
  output logic                                  alu_ready_o,
  input  logic [4:0]                            alu_waddr_i,
  input  logic [DataWidth-1:0]                  alu_wdata_i,
  input  logic                                  lsu_issue_i,
  input  logic [4:0]                            lsu_issue_waddr_i,
  output logic                                  lsu_issue_ready_o,
  input  logic                                  lsu_rvalid_i,
  input  logic [DataWidth-1:0]                  lsu_rdata_i,
  input  logic [4:0]                            raddr_a_i,
  input  logic [4:0]                            raddr_b_i,
  output logic                                  hazard_a_o,
  output logic                                  hazard_b_o,
  output logic [4:0]                            rf_waddr_o,
  output logic [DataWidth-1:0]                  rf_wdata_o,
  output logic                                  rf_we_o,
  output logic                                  rsp_err_o,
  output logic [$clog2(LsuOutstanding+1)-1:0]   outstanding_o
);

  localparam int unsigned PtrW = (LsuOutstanding > 1) ? $clog2(LsuOutstanding) : 1;
  localparam int unsigned CntW = $clog2(LsuOutstanding + 1);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(LsuOutstanding - 1);
  localparam logic [CntW-1:0] Depth   = CntW'(LsuOutstanding);

  // RV32E only decodes 16 registers, so bit 4 is dropped before any compare.
  function automatic logic [4:0] addr_mask(input logic [4:0] a);
    return RV32E ? {1'b0, a[3:0]} : a;
  endfunction

  // Circular-buffer pointer increment wrapping at the FIFO depth.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == LastPtr) ? {PtrW{1'b0}} : p + PtrW'(1);
  endfunction

  logic [4:0]                waddr_r [LsuOutstanding];
  logic [LsuOutstanding-1:0] valid_r;
  logic [PtrW-1:0]           rd_ptr_r;
  logic [PtrW-1:0]           wr_ptr_r;
  logic [CntW-1:0]           count_r;
  logic                      rsp_err_r;

  logic        empty_s;
  logic        pop_s;
  logic        push_s;
  logic [4:0]  issue_idx_s;
  logic        issue_valid_s;
  logic [4:0]  alu_idx_s;
  logic [4:0]  ra_idx_s;
  logic [4:0]  rb_idx_s;
  logic [31:0] pending_s;
  logic        fwd_a_s;
  logic        fwd_b_s;

  assign empty_s       = (count_r == {CntW{1'b0}});
  assign pop_s         = lsu_rvalid_i & ~empty_s;
  assign issue_idx_s   = addr_mask(lsu_issue_waddr_i);
  // A load to x0 still takes a slot so responses stay matched, but never hazards.
  assign issue_valid_s = (issue_idx_s != 5'd0);
  assign alu_idx_s     = addr_mask(alu_waddr_i);
  assign ra_idx_s      = addr_mask(raddr_a_i);
  assign rb_idx_s      = addr_mask(raddr_b_i);

  // A full FIFO can still take a push when the head pops in the same cycle.
  assign lsu_issue_ready_o = (count_r < Depth) | pop_s;
  assign push_s            = lsu_issue_i & lsu_issue_ready_o;

  // The LSU response always wins the port; pending loads block a WAW ALU write.
  assign alu_ready_o = rst_ni & ~lsu_rvalid_i & ~pending_s[alu_idx_s];

  assign outstanding_o = count_r;
  assign rsp_err_o     = rsp_err_r;

  // Pending-destination vector: OR of one-hot addresses of valid entries.
  always_comb begin
    pending_s = 32'd0;
    for (int i = 0; i < LsuOutstanding; i++) begin
      pending_s = pending_s | (32'(valid_r[i]) << waddr_r[i]);
    end
  end

`ifdef IBEX_RF_WR_ARB_FWD_EN
  logic other_a_s;
  logic other_b_s;

  // Drop the hazard when the popping head is the only valid entry for that register.
  always_comb begin
    other_a_s = 1'b0;
    other_b_s = 1'b0;
    for (int i = 0; i < LsuOutstanding; i++) begin
      other_a_s = other_a_s | ((PtrW'(i) != rd_ptr_r) & valid_r[i] & (waddr_r[i] == ra_idx_s));
      other_b_s = other_b_s | ((PtrW'(i) != rd_ptr_r) & valid_r[i] & (waddr_r[i] == rb_idx_s));
    end
    fwd_a_s = pop_s & valid_r[rd_ptr_r] & (waddr_r[rd_ptr_r] == ra_idx_s) & ~other_a_s;
    fwd_b_s = pop_s & valid_r[rd_ptr_r] & (waddr_r[rd_ptr_r] == rb_idx_s) & ~other_b_s;
  end
`else
  assign fwd_a_s = 1'b0;
  assign fwd_b_s = 1'b0;
`endif

  assign hazard_a_o = pending_s[ra_idx_s] & ~fwd_a_s;
  assign hazard_b_o = pending_s[rb_idx_s] & ~fwd_b_s;

  // Write-port mux: load response first, then an accepted ALU write, else idle zeros.
  always_comb begin
    rf_we_o    = 1'b0;
    rf_waddr_o = 5'd0;
    rf_wdata_o = {DataWidth{1'b0}};
    if (pop_s) begin
      if (valid_r[rd_ptr_r]) begin
        rf_we_o    = 1'b1;
        rf_waddr_o = waddr_r[rd_ptr_r];
        rf_wdata_o = lsu_rdata_i;
      end else begin
        rf_we_o = 1'b0;
      end
    end else if (alu_valid_i && alu_ready_o && (alu_idx_s != 5'd0)) begin
      rf_we_o    = 1'b1;
      rf_waddr_o = alu_idx_s;
      rf_wdata_o = alu_wdata_i;
    end else begin
      rf_we_o = 1'b0;
    end
  end

  // FIFO state and error pulse; a push into the popping slot overrides its clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_r  <= {PtrW{1'b0}};
      wr_ptr_r  <= {PtrW{1'b0}};
      count_r   <= {CntW{1'b0}};
      valid_r   <= {LsuOutstanding{1'b0}};
      rsp_err_r <= 1'b0;
      for (int i = 0; i < LsuOutstanding; i++) begin
        waddr_r[i] <= 5'd0;
      end
    end else begin
      if (pop_s) begin
        valid_r[rd_ptr_r] <= 1'b0;
        rd_ptr_r          <= ptr_inc(rd_ptr_r);
      end
      if (push_s) begin
        valid_r[wr_ptr_r] <= issue_valid_s;
        waddr_r[wr_ptr_r] <= issue_idx_s;
        wr_ptr_r          <= ptr_inc(wr_ptr_r);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CntW'(1);
        2'b01:   count_r <= count_r - CntW'(1);
        default: count_r <= count_r;
      endcase
      rsp_err_r <= lsu_rvalid_i & empty_s;
    end
  end

endmodule

// File: tb/tb_ibex_rf_wr_arbiter.sv
// Self-checking bench for ibex_rf_wr_arbiter (defaults: 32 regs, depth 2).
// Per-cycle vectors check control outputs. A write scoreboard checks every
// register-file write in order.
module tb_ibex_rf_wr_arbiter;

`ifdef IBEX_RF_WR_ARB_FWD_EN
  localparam bit Fwd = 1'b1;
`else
  localparam bit Fwd = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        alu_valid_i;
  logic        alu_ready_o;
  logic [4:0]  alu_waddr_i;
  logic [31:0] alu_wdata_i;
  logic        lsu_issue_i;
  logic [4:0]  lsu_issue_waddr_i;
  logic        lsu_issue_ready_o;
  logic        lsu_rvalid_i;
  logic [31:0] lsu_rdata_i;
  logic [4:0]  raddr_a_i;
  logic [4:0]  raddr_b_i;
  logic        hazard_a_o;
  logic        hazard_b_o;
  logic [4:0]  rf_waddr_o;
  logic [31:0] rf_wdata_o;
  logic        rf_we_o;
  logic        rsp_err_o;
  logic [1:0]  outstanding_o;

  ibex_rf_wr_arbiter dut (
    .clk_i             (clk_i),
    .rst_ni            (rst_ni),
    .alu_valid_i       (alu_valid_i),
    .alu_ready_o       (alu_ready_o),
    .alu_waddr_i       (alu_waddr_i),
    .alu_wdata_i       (alu_wdata_i),
    .lsu_issue_i       (lsu_issue_i),
    .lsu_issue_waddr_i (lsu_issue_waddr_i),
    .lsu_issue_ready_o (lsu_issue_ready_o),
    .lsu_rvalid_i      (lsu_rvalid_i),
    .lsu_rdata_i       (lsu_rdata_i),
    .raddr_a_i         (raddr_a_i),
    .raddr_b_i         (raddr_b_i),
    .hazard_a_o        (hazard_a_o),
    .hazard_b_o        (hazard_b_o),
    .rf_waddr_o        (rf_waddr_o),
    .rf_wdata_o        (rf_wdata_o),
    .rf_we_o           (rf_we_o),
    .rsp_err_o         (rsp_err_o),
    .outstanding_o     (outstanding_o)
  );

  // Free-running 10-time-unit clock.
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        av;  logic [4:0] aa; logic [31:0] ad;
    logic        li;  logic [4:0] la;
    logic        rv;  logic [31:0] rd;
    logic [4:0]  ra;  logic [4:0] rb;
    logic        e_ar; logic e_ir; logic e_ha; logic e_hb; logic e_we;
    logic [4:0]  e_wa; logic [31:0] e_wd; logic [1:0] e_out; logic e_err;
  } vec_t;

  typedef struct packed { logic [4:0] a; logic [31:0] d; } wr_t;

  int   errors = 0;
  int   checks = 0;
  wr_t  sb_q[$];
  vec_t vt[$];

  function automatic vec_t mk(
    input logic av, input logic [4:0] aa, input logic [31:0] ad,
    input logic li, input logic [4:0] la,
    input logic rv, input logic [31:0] rd,
    input logic [4:0] ra, input logic [4:0] rb,
    input logic ear, input logic eir, input logic eha, input logic ehb,
    input logic ewe, input logic [4:0] ewa, input logic [31:0] ewd,
    input logic [1:0] eout, input logic eerr);
    vec_t v;
    v.av = av; v.aa = aa; v.ad = ad; v.li = li; v.la = la; v.rv = rv; v.rd = rd;
    v.ra = ra; v.rb = rb; v.e_ar = ear; v.e_ir = eir; v.e_ha = eha; v.e_hb = ehb;
    v.e_we = ewe; v.e_wa = ewa; v.e_wd = ewd; v.e_out = eout; v.e_err = eerr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Compare the current write port against the scoreboard head.
  task automatic sample_sb(input string tag);
    wr_t e;
    if (rf_we_o === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL %s_sb_unexpected: got write x%0d=%h expected none", tag, rf_waddr_o, rf_wdata_o);
      end else begin
        e = sb_q.pop_front();
        chk({tag, "_sb_waddr"}, {27'd0, rf_waddr_o}, {27'd0, e.a});
        chk({tag, "_sb_wdata"}, rf_wdata_o, e.d);
      end
    end else begin
      chk({tag, "_idle_waddr"}, {27'd0, rf_waddr_o}, 32'd0);
      chk({tag, "_idle_wdata"}, rf_wdata_o, 32'd0);
    end
  endtask

  // Drive one vector for a cycle; sample on the falling edge.
  task automatic apply(input vec_t v, input string tag);
    alu_valid_i = v.av; alu_waddr_i = v.aa; alu_wdata_i = v.ad;
    lsu_issue_i = v.li; lsu_issue_waddr_i = v.la;
    lsu_rvalid_i = v.rv; lsu_rdata_i = v.rd;
    raddr_a_i = v.ra; raddr_b_i = v.rb;
    if (v.e_we) sb_q.push_back({v.e_wa, v.e_wd});
    @(negedge clk_i);
    chk({tag, "_alu_ready"}, {31'd0, alu_ready_o}, {31'd0, v.e_ar});
    chk({tag, "_issue_ready"}, {31'd0, lsu_issue_ready_o}, {31'd0, v.e_ir});
    chk({tag, "_hazard_a"}, {31'd0, hazard_a_o}, {31'd0, v.e_ha});
    chk({tag, "_hazard_b"}, {31'd0, hazard_b_o}, {31'd0, v.e_hb});
    chk({tag, "_we"}, {31'd0, rf_we_o}, {31'd0, v.e_we});
    chk({tag, "_outstanding"}, {30'd0, outstanding_o}, {30'd0, v.e_out});
    chk({tag, "_rsp_err"}, {31'd0, rsp_err_o}, {31'd0, v.e_err});
    sample_sb(tag);
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    alu_valid_i = 1'b0; alu_waddr_i = 5'd0; alu_wdata_i = 32'd0;
    lsu_issue_i = 1'b0; lsu_issue_waddr_i = 5'd0;
    lsu_rvalid_i = 1'b0; lsu_rdata_i = 32'd0;
    raddr_a_i = 5'd0; raddr_b_i = 5'd0;
  endtask

  initial begin
    logic h;
    h = ~Fwd;  // hazard seen in the load-write cycle only without forwarding

    //            av   aa     ad            li   la     rv   rd            ra     rb     ar   ir   ha   hb   we   wa     wd            out   err
    vt.push_back(mk(1'b1,5'd5, 32'hDEADBEEF,1'b0,5'd0, 1'b0,32'h0,        5'd0, 5'd0, 1'b1,1'b1,1'b0,1'b0,1'b1,5'd5, 32'hDEADBEEF,2'd0,1'b0));
    vt.push_back(mk(1'b0,5'd0, 32'h0,       1'b1,5'd7, 1'b0,32'h0,        5'd7, 5'd0, 1'b1,1'b1,1'b0,1'b0,1'b0,5'd0, 32'h0,       2'd0,1'b0));
    vt.push_back(mk(1'b0,5'd0, 32'h0,       1'b0,5'd0, 1'b0,32'h0,        5'd7, 5'd0, 1'b1,1'b1,1'b1,1'b0,1'b0,5'd0, 32'h0,       2'd1,1'b0));
    vt.push_back(mk(1'b0,5'd0, 32'h0,       1'b0,5'd0, 1'b1,32'h1234,     5'd7, 5'd0, 1'b0,1'b1,h,   1'b0,1'b1,5'd7, 32'h1234,    2'd1,1'b0));
    vt.push_back(mk(1'b0,5'd0, 32'h0,       1'b0,5'd0, 1'b0,32'h0,        5'd7, 5'd0, 1'b1,1'b1,1'b0,1'b0,1'b0,5'd0, 32'h0,       2'd0,1'b0));
    vt.push_back(mk(1'b0,5'd0, 32'h0,       1'b1,5'd9, 1'b0,32'h0,        5'd0, 5'd0, 1'b1,1'b1,1'b0,1'b0,1'b0,5'd0, 32'h0,       2'd0,1'b0));
    vt.push_back(mk(1'b1,5'd3, 32'hAA,      1'b0,5'd0, 1'b1,32'hBB,       5'd9, 5'd3, 1'b0,1'b1,h,   1'b0,1'b1,5'd9, 32'hBB,      2'd1,1'b0));
    vt.push_back(mk(1'b1,5'd3, 32'hAA,      1'b0,5'd0, 1'b0,32'h0,        5'd9, 5'd3, 1'b1,1'b1,1'b0,1'b0,1'b1,5'd3, 32'hAA,      2'd0,1'b0));
    vt.push_back(mk(1'b0,5'd0, 32'h0,       1'b1,5'd4, 1'b0,32'h0,        5'd0, 5'd0, 1'b1,1'b1,1'b0,1'b0,1'b0,5'd0, 32'h0,       2'd0,1'b0));
    vt.push_back(mk(1'b1,5'd4, 32'h1,       1'b0,5'd0, 1'b0,32'h0,        5'd0, 5'd4, 1'b0,1'b1,1'b0,1'b1,1'b0,5'd0, 32'h0,       2'd1,1'b0));
    vt.push_back(mk(1'b1,5'd4, 32'h1,       1'b0,5'd0, 1'b0,32'h0,        5'd0, 5'd4, 1'b0,1'b1,1'b0,1'b1,1'b0,5'd0, 32'h0,       2'd1,1'b0));
    vt.push_back(mk(1'b1,5'd4, 32'h1,       1'b0,5'd0, 1'b1,32'h55,       5'd0, 5'd4, 1'b0,1'b1,1'b0,h,   1'b1,5'd4, 32'h55,      2'd1,1'b0));
    vt.push_back(mk(1'b1,5'd4, 32'h1,       1'b0,5'd0, 1'b0,32'h0,        5'd0, 5'd4, 1'b1,1'b1,1'b0,1'b0,1'b1,5'd4, 32'h1,       2'd0,1'b0));
    vt.push_back(mk(1'b0,5'd0, 32'h0,       1'b1,5'd1, 1'b0,32'h0,        5'd0, 5'd0, 1'b1,1'b1,1'b0,1'b0,1'b0,5'd0, 32'h0,       2'd0,1'b0));
    vt.push_back(mk(1'b0,5'd0, 32'h0,       1'b1,5'd2, 1'b0,32'h0,        5'd1, 5'd0, 1'b1,1'b1,1'b1,1'b0,1'b0,5'd0, 32'h0,       2'd1,1'b0));
    vt.push_back(mk(1'b0,5'd0, 32'h0,       1'b0,5'd0, 1'b0,32'h0,        5'd1, 5'd2, 1'b1,1'b0,1'b1,1'b1,1'b0,5'd0, 32'h0,       2'd2,1'b0));
    vt.push_back(mk(1'b0,5'd0, 32'h0,       1'b1,5'd3, 1'b1,32'h111,      5'd1, 5'd2, 1'b0,1'b1,h,   1'b1,1'b1,5'd1, 32'h111,     2'd2,1'b0));
    vt.push_back(mk(1'b0,5'd0, 32'h0,       1'b0,5'd0, 1'b0,32'h0,        5'd2, 5'd3, 1'b1,1'b0,1'b1,1'b1,1'b0,5'd0, 32'h0,       2'd2,1'b0));
    vt.push_back(mk(1'b0,5'd0, 32'h0,       1'b0,5'd0, 1'b1,32'h222,      5'd2, 5'd3, 1'b0,1'b1,h,   1'b1,1'b1,5'd2, 32'h222,     2'd2,1'b0));
    vt.push_back(mk(1'b0,5'd0, 32'h0,       1'b0,5'd0, 1'b1,32'h333,      5'd0, 5'd3, 1'b0,1'b1,1'b0,h,   1'b1,5'd3, 32'h333,     2'd1,1'b0));
    vt.push_back(mk(1'b0,5'd0, 32'h0,       1'b0,5'd0, 1'b1,32'hDEAD,     5'd0, 5'd0, 1'b0,1'b1,1'b0,1'b0,1'b0,5'd0, 32'h0,       2'd0,1'b0));
    vt.push_back(mk(1'b0,5'd0, 32'h0,       1'b0,5'd0, 1'b0,32'h0,        5'd0, 5'd0, 1'b1,1'b1,1'b0,1'b0,1'b0,5'd0, 32'h0,       2'd0,1'b1));
    vt.push_back(mk(1'b0,5'd0, 32'h0,       1'b0,5'd0, 1'b0,32'h0,        5'd0, 5'd0, 1'b1,1'b1,1'b0,1'b0,1'b0,5'd0, 32'h0,       2'd0,1'b0));
    vt.push_back(mk(1'b0,5'd0, 32'h0,       1'b1,5'd0, 1'b0,32'h0,        5'd0, 5'd0, 1'b1,1'b1,1'b0,1'b0,1'b0,5'd0, 32'h0,       2'd0,1'b0));
    vt.push_back(mk(1'b0,5'd0, 32'h0,       1'b0,5'd0, 1'b0,32'h0,        5'd0, 5'd0, 1'b1,1'b1,1'b0,1'b0,1'b0,5'd0, 32'h0,       2'd1,1'b0));
    vt.push_back(mk(1'b0,5'd0, 32'h0,       1'b0,5'd0, 1'b1,32'h77,       5'd0, 5'd0, 1'b0,1'b1,1'b0,1'b0,1'b0,5'd0, 32'h0,       2'd1,1'b0));
    vt.push_back(mk(1'b0,5'd0, 32'h0,       1'b0,5'd0, 1'b0,32'h0,        5'd0, 5'd0, 1'b1,1'b1,1'b0,1'b0,1'b0,5'd0, 32'h0,       2'd0,1'b0));
    vt.push_back(mk(1'b1,5'd0, 32'h5,       1'b0,5'd0, 1'b0,32'h0,        5'd0, 5'd0, 1'b1,1'b1,1'b0,1'b0,1'b0,5'd0, 32'h0,       2'd0,1'b0));

    // Reset: outputs held idle even with an ALU request present.
    idle_inputs();
    rst_ni = 1'b0;
    alu_valid_i = 1'b1; alu_waddr_i = 5'd5; alu_wdata_i = 32'h1;
    #12;
    chk("rst_alu_ready", {31'd0, alu_ready_o}, 32'd0);
    chk("rst_we", {31'd0, rf_we_o}, 32'd0);
    chk("rst_issue_ready", {31'd0, lsu_issue_ready_o}, 32'd1);
    chk("rst_outstanding", {30'd0, outstanding_o}, 32'd0);
    chk("rst_rsp_err", {31'd0, rsp_err_o}, 32'd0);
    chk("rst_hazards", {30'd0, hazard_a_o, hazard_b_o}, 32'd0);
    idle_inputs();
    #1 rst_ni = 1'b1;
    @(posedge clk_i);
    #1;

    for (int i = 0; i < vt.size(); i++) begin
      apply(vt[i], $sformatf("row%0d", i));
    end

    // Reset in the middle of two outstanding loads.
    apply(mk(1'b0,5'd0,32'h0, 1'b1,5'd10, 1'b0,32'h0, 5'd10,5'd11, 1'b1,1'b1,1'b0,1'b0,1'b0,5'd0,32'h0, 2'd0,1'b0), "mrst0");
    apply(mk(1'b0,5'd0,32'h0, 1'b1,5'd11, 1'b0,32'h0, 5'd10,5'd11, 1'b1,1'b1,1'b1,1'b0,1'b0,5'd0,32'h0, 2'd1,1'b0), "mrst1");
    idle_inputs();
    raddr_a_i = 5'd10; raddr_b_i = 5'd11;
    alu_valid_i = 1'b1; alu_waddr_i = 5'd12; alu_wdata_i = 32'hC0FFEE;
    #1;
    chk("mrst_pre_haz", {30'd0, hazard_a_o, hazard_b_o}, 32'd3);
    chk("mrst_pre_out", {30'd0, outstanding_o}, 32'd2);
    rst_ni = 1'b0;
    #1;
    chk("mrst_out", {30'd0, outstanding_o}, 32'd0);
    chk("mrst_haz", {30'd0, hazard_a_o, hazard_b_o}, 32'd0);
    chk("mrst_alu_ready", {31'd0, alu_ready_o}, 32'd0);
    chk("mrst_we", {31'd0, rf_we_o}, 32'd0);
    #1 rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    apply(mk(1'b1,5'd12,32'hC0FFEE, 1'b0,5'd0, 1'b0,32'h0, 5'd10,5'd11, 1'b1,1'b1,1'b0,1'b0,1'b1,5'd12,32'hC0FFEE, 2'd0,1'b0), "mrst_post");

    chk("sb_drained", sb_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
